trig_freq_meter: RTL
====================

// Module: trig_freq_meter
// PURPOSE
//  Hysteretic trigger-crossing detector and gated frequency/period counter on the 12-bit ADC
//  sample stream. Sits directly upstream of the measurement/display stage.
//  Delivers frequency (rising crossings per gate window) and last crossing-to-crossing period.
// PARAMETERS
//  GATE_CYCLES  50_000_000  gate window length in CLK cycles (1 s at 50 MHz -> frequency in Hz)
//  HYST         2           hysteresis half-width, ADC codes (0..255)
// PORTS
//  CLK          in   1   system clock, all logic on rising edge
//  RSTB         in   1   reset, asynchronous, active-high
//  EN           in   1   measurement enable
//  DATA_VALID   in   1   DATA_IN qualifier; samples used only when high
//  DATA_IN      in   12  unsigned ADC sample
//  TRIG         in   12  unsigned trigger level, sampled every cycle
//  frequency    out  24  rising crossings counted in last completed gate window
//  freq_valid   out  1   one-cycle pulse when frequency/freq_ovf update
//  freq_ovf     out  1   last window's count saturated
//  period       out  32  CLK cycles between last two rising crossings
//  period_valid out  1   one-cycle pulse when period updates
// BEHAVIOUR
//  Reset: all outputs 0; crossing state UNKNOWN; gate_cnt=0; edge_cnt=0; per_cnt=0; have_edge=0.
//  Thresholds (13-bit compute, then clamp): hi=min(TRIG+HYST,4095); lo=max(TRIG-HYST,0).
//  Crossing FSM, advances only on EN & DATA_VALID:
//   UNKNOWN: DATA_IN>=hi -> ABOVE; DATA_IN<=lo -> BELOW; else stay. Never counts an edge.
//   BELOW:   DATA_IN>=hi -> ABOVE, rising edge event (rise=1 that cycle).
//   ABOVE:   DATA_IN<=lo -> BELOW. No event.
//   Samples strictly between lo and hi never change state.
//  Gate counter: free-runs 0..GATE_CYCLES-1 while EN=1.
//   Terminal cycle (gate_cnt==GATE_CYCLES-1): frequency<=edge_cnt+rise (saturated),
//   freq_ovf<=saturated flag, freq_valid=1 next cycle (registered, latency 1),
//   edge_cnt<=0, gate_cnt<=0. Edge in terminal cycle belongs to closing window.
//   Otherwise edge_cnt+=rise, saturating at 24'hFFFFFF.
//  Period counter: per_cnt increments every EN cycle, saturating at 32'hFFFFFFFF.
//   On rise: if have_edge, period<=per_cnt+1 (saturated), period_valid pulse next cycle;
//   then per_cnt<=0, have_edge<=1. First rise after reset/EN only arms (no period output).
//  EN=0: FSM->UNKNOWN, gate_cnt/edge_cnt/per_cnt/have_edge cleared; frequency, freq_ovf,
//   period hold last values; no valid pulses. EN 0->1 starts a fresh full window.
//  TRIG change mid-window: new thresholds apply next cycle; FSM state retained, no forced event.
//  freq_valid and period_valid may pulse in the same cycle.
//  RSTB asserted mid-window: immediate clear per reset values; partial window discarded.
// TESTING (bench: GATE_CYCLES=1200, HYST=2, TRIG=1002, 20 ns CLK, DATA_VALID=1)
//  Triangle 1000,1002..1012,1010..1002 repeating, each step 10 cycles -> period=120 every cycle
//   of waveform after the first; frequency=10 on every window after the first.
//  DATA_IN constant 1003 (inside band) -> FSM stays UNKNOWN, frequency=0, no period_valid.
//  Alternate 0/4095 every cycle with GATE_CYCLES=16, 24-bit count forced near max via
//   force/release -> frequency=24'hFFFFFF, freq_ovf=1; next normal window freq_ovf=0.
//  Rise exactly on terminal gate cycle -> counted in closing window; next window starts at 0.
//  EN low for 50 cycles mid-window -> no freq_valid; outputs hold; first freq_valid exactly
//   GATE_CYCLES+1 cycles after EN rises; first rise after EN only arms period.
//  RSTB pulse mid-window -> all outputs 0 same cycle (async); TRIG=2 with HYST=2 -> lo=0, hi=4.

Source files
------------

// File: rtl/trig_freq_meter.sv
// trig_freq_meter: hysteretic trigger-crossing detector with gated
// frequency counter and crossing-to-crossing period counter.
// Ports:
//   CLK, RSTB (async, active-high), EN, DATA_VALID, DATA_IN[11:0], TRIG[11:0]
//   frequency[23:0], freq_valid, freq_ovf, period[31:0], period_valid
module trig_freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int HYST        = 2
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        EN,
    input  logic        DATA_VALID,
    input  logic [11:0] DATA_IN,
    input  logic [11:0] TRIG,
    output logic [23:0] frequency,
    output logic        freq_valid,
    output logic        freq_ovf,
    output logic [31:0] period,
    output logic        period_valid
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [12:0] HYST13 = 13'(HYST);

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_BELOW   = 2'd1;
    localparam logic [1:0] ST_ABOVE   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [11:0]   hi_q;
    logic [11:0]   lo_q;
    logic [GW-1:0] gate_cnt;
    logic [23:0]   edge_cnt;
    logic [31:0]   per_cnt;
    logic          have_edge;

    // Thresholds in 13 bits so both ends clamp instead of wrapping.
    logic [12:0] hi_sum;
    logic [12:0] lo_diff;
    logic [11:0] hi;
    logic [11:0] lo;

    assign hi_sum  = {1'b0, TRIG} + HYST13;
    assign lo_diff = {1'b0, TRIG} - HYST13;
    assign hi      = hi_sum[12] ? 12'hFFF : hi_sum[11:0];
    assign lo      = lo_diff[12] ? 12'h000 : lo_diff[11:0];

    logic adv;
    logic ge_hi;
    logic le_lo;
    logic rise;
    logic term;

    assign adv   = EN & DATA_VALID;
    assign ge_hi = DATA_IN >= hi_q;
    assign le_lo = DATA_IN <= lo_q;
    assign rise  = adv && (state == ST_BELOW) && ge_hi;
    assign term  = EN && (gate_cnt == GATE_LAST);

    // Saturating edge count including this cycle's crossing.
    logic [24:0] edge_sum;
    logic [23:0] edge_sat;
    logic        win_ovf;

    assign edge_sum = {1'b0, edge_cnt} + 25'(rise);
    assign edge_sat = edge_sum[24] ? 24'hFFFFFF : edge_sum[23:0];
    assign win_ovf  = edge_sum >= 25'h0FFFFFF;

    logic [32:0] per_sum;
    logic [31:0] per_sat;

    assign per_sum = {1'b0, per_cnt} + 33'd1;
    assign per_sat = per_sum[32] ? 32'hFFFFFFFF : per_sum[31:0];

    always_comb begin
        state_nxt = state;
        if (!EN) begin
            state_nxt = ST_UNKNOWN;
        end else if (adv) begin
            case (state)
                ST_UNKNOWN: begin
                    if (ge_hi)      state_nxt = ST_ABOVE;
                    else if (le_lo) state_nxt = ST_BELOW;
                end
                ST_BELOW: if (ge_hi) state_nxt = ST_ABOVE;
                ST_ABOVE: if (le_lo) state_nxt = ST_BELOW;
                default:  state_nxt = ST_UNKNOWN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            state        <= ST_UNKNOWN;
            hi_q         <= 12'hFFF;
            lo_q         <= 12'h000;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            per_cnt      <= '0;
            have_edge    <= 1'b0;
            frequency    <= '0;
            freq_valid   <= 1'b0;
            freq_ovf     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            hi_q         <= hi;
            lo_q         <= lo;
            state        <= state_nxt;
            freq_valid   <= 1'b0;
            period_valid <= 1'b0;
            if (!EN) begin
                gate_cnt  <= '0;
                edge_cnt  <= '0;
                per_cnt   <= '0;
                have_edge <= 1'b0;
            end else begin
                // A crossing on the terminal cycle closes with this window.
                if (term) begin
                    frequency  <= edge_sat;
                    freq_ovf   <= win_ovf;
                    freq_valid <= 1'b1;
                    edge_cnt   <= '0;
                    gate_cnt   <= '0;
                end else begin
                    edge_cnt <= edge_sat;
                    gate_cnt <= gate_cnt + 1'b1;
                end
                // The first crossing only arms the period measurement.
                if (rise) begin
                    if (have_edge) begin
                        period       <= per_sat;
                        period_valid <= 1'b1;
                    end
                    per_cnt   <= '0;
                    have_edge <= 1'b1;
                end else begin
                    per_cnt <= per_sat;
                end
            end
        end
    end

endmodule
